// File: rtl/dfm_pkg.sv
// Shared definitions for the frequency measurement channels.
package dfm_pkg;

  // Measurement FSM states of one gate_counter channel.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    GATE = 2'd2,
    DONE = 2'd3
  } gc_state_t;

  // Default width of the reference and signal counters.
  localparam int CNT_WIDTH_DEF = 32;

  // Result written when no usable signal edge was seen: ref half all ones, sig half zero.
  localparam logic [2*CNT_WIDTH_DEF-1:0] NO_SIGNAL_WORD =
    {{CNT_WIDTH_DEF{1'b1}}, {CNT_WIDTH_DEF{1'b0}}};

endpackage

// File: rtl/sig_edge_sync.sv
// Brings the asynchronous signal under test into the clk_i domain and flags its rising edges.
module sig_edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic sig_i,
  output logic sig_rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   prev_q;

  // Shift the raw input in at the low end; the top bit is the synchronized value.
  assign sync_d = SYNC_STAGES'({sync_q, sig_i});

  // Synchronizer chain plus one extra flop holding the previous synchronized value.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sig_rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/gate_counter.sv
// Equal-precision frequency measurement: counts clk_i cycles and signal edges over a
// gate that opens and closes on signal rising edges, then emits one result word.
module gate_counter
  import dfm_pkg::*;
#(
  parameter int unsigned CNT_WIDTH      = CNT_WIDTH_DEF,
  parameter int unsigned GATE_CYCLES    = 50_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 100_000_000,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   sig_clk_i,
  input  logic                   gate_en_i,
  output logic                   reg_wr_en_o,
  output logic [2*CNT_WIDTH-1:0] reg_wr_data_o,
  output logic                   gate_sync_o
);

  localparam int unsigned TmrW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TmrW-1:0] GateLen    = TmrW'(GATE_CYCLES);
  localparam logic [TmrW-1:0] TimeoutLen = TmrW'(TIMEOUT_CYCLES);
  localparam logic [2*CNT_WIDTH-1:0] NoSignal =
    {{CNT_WIDTH{NO_SIGNAL_WORD[2*CNT_WIDTH_DEF-1]}}, {CNT_WIDTH{NO_SIGNAL_WORD[0]}}};

  gc_state_t              state_q, state_d;
  logic [CNT_WIDTH-1:0]   ref_q, ref_d, ref_inc;
  logic [CNT_WIDTH-1:0]   sig_q, sig_d, sig_inc;
  logic [TmrW-1:0]        timer_q, timer_d, timer_inc;
  logic [2*CNT_WIDTH-1:0] data_q, data_d;
  logic                   sig_rise;

  sig_edge_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .sig_i      (sig_clk_i),
    .sig_rise_o (sig_rise)
  );

  // Saturating increments; in GATE timer_inc equals the cycles elapsed since the opening edge.
  assign ref_inc   = (ref_q == '1) ? ref_q : ref_q + 1'b1;
  assign sig_inc   = (sig_q == '1) ? sig_q : sig_q + 1'b1;
  assign timer_inc = (timer_q >= TimeoutLen) ? TimeoutLen : timer_q + 1'b1;

  // Next-state logic: abort beats everything, a closing edge beats the timeout.
  always_comb begin
    state_d = state_q;
    ref_d   = ref_q;
    sig_d   = sig_q;
    timer_d = timer_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (gate_en_i) begin
          state_d = ARM;
          timer_d = '0;
        end
      end
      ARM: begin
        if (!gate_en_i) begin
          state_d = IDLE;
        end else if (sig_rise) begin
          state_d = GATE;
          ref_d   = '0;
          sig_d   = '0;
          timer_d = '0;
        end else if (timer_q >= TimeoutLen) begin
          state_d = DONE;
          data_d  = NoSignal;
        end else begin
          timer_d = timer_inc;
        end
      end
      GATE: begin
        if (!gate_en_i) begin
          state_d = IDLE;
        end else begin
          ref_d   = ref_inc;
          timer_d = timer_inc;
          if (sig_rise) begin
            sig_d = sig_inc;
          end
          if (sig_rise && (timer_inc >= GateLen)) begin
            state_d = DONE;
            data_d  = {ref_inc, sig_inc};
          end else if (timer_inc >= TimeoutLen) begin
            state_d = DONE;
            data_d  = NoSignal;
          end
        end
      end
      DONE: begin
        if (gate_en_i) begin
          state_d = ARM;
          timer_d = '0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counters, timer and the held result word.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      ref_q   <= '0;
      sig_q   <= '0;
      timer_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ref_q   <= ref_d;
      sig_q   <= sig_d;
      timer_q <= timer_d;
      data_q  <= data_d;
    end
  end

  assign reg_wr_en_o   = (state_q == DONE);
  assign gate_sync_o   = (state_q == GATE);
  assign reg_wr_data_o = data_q;

endmodule

// File: tb/tb_gate_counter.sv
// Randomized self-checking bench for gate_counter with short gate/timeout lengths.
`timescale 1ns/1ps
module tb_gate_counter;

  localparam int CW     = 32;
  localparam int GLEN   = 100;
  localparam int TOLEN  = 400;
  localparam logic [63:0] NoSig = {32'hFFFF_FFFF, 32'h0000_0000};

  logic             clk_i = 1'b0;
  logic             rst_n_i;
  logic             sig_clk_i;
  logic             gate_en_i;
  logic             reg_wr_en_o;
  logic [2*CW-1:0]  reg_wr_data_o;
  logic             gate_sync_o;

  int testsRun    = 0;
  int testsFailed = 0;
  int sigPeriod   = 0;
  int sigPhase    = 3;
  bit sigBusy     = 1'b0;

  gate_counter #(
    .CNT_WIDTH      (CW),
    .GATE_CYCLES    (GLEN),
    .TIMEOUT_CYCLES (TOLEN),
    .SYNC_STAGES    (2)
  ) dut (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .sig_clk_i     (sig_clk_i),
    .gate_en_i     (gate_en_i),
    .reg_wr_en_o   (reg_wr_en_o),
    .reg_wr_data_o (reg_wr_data_o),
    .gate_sync_o   (gate_sync_o)
  );

  // 10 ns system clock.
  always #5 clk_i = ~clk_i;

  // Periodic signal source, period in whole clk cycles, edges offset from clk edges by sigPhase ns.
  initial begin
    int curP;
    sig_clk_i = 1'b0;
    forever begin
      wait (sigPeriod != 0);
      sigBusy = 1'b1;
      @(posedge clk_i);
      #(sigPhase);
      while (sigPeriod != 0) begin
        curP = sigPeriod;
        sig_clk_i = 1'b1;
        #((curP / 2) * 10);
        sig_clk_i = 1'b0;
        #((curP - curP / 2) * 10);
      end
      sigBusy = 1'b0;
    end
  end

  // Absolute time limit so the run always ends.
  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Reference model: gate closes on the first edge at least GLEN cycles after the opening one.
  function automatic int edgesInGate(input int p);
    return (GLEN + p - 1) / p;
  endfunction

  function automatic logic [63:0] expWord(input int p);
    int n;
    n = edgesInGate(p);
    return {32'(n * p), 32'(n)};
  endfunction

  // Stop the current signal (it ends low) and start a new one; period 0 keeps it low.
  task automatic applyStimulus(input int period);
    sigPeriod = 0;
    for (int i = 0; i < 200 && sigBusy; i++) @(posedge clk_i);
    sigPhase  = int'($urandom_range(9, 1));
    sigPeriod = period;
  endtask

  task automatic waitStrobe(input int budget, output bit seen, output int cycles, output int gateHigh);
    seen = 1'b0;
    cycles = 0;
    gateHigh = 0;
    while (!seen && cycles < budget) begin
      @(posedge clk_i);
      #1;
      cycles++;
      if (reg_wr_en_o) seen = 1'b1;
      else if (gate_sync_o) gateHigh++;
    end
  endtask

  task automatic measureAndCheck(input string tag, input logic [63:0] word, input int gateLen, input int exactCyc);
    bit seen;
    int cyc, gh;
    waitStrobe(1500, seen, cyc, gh);
    checkOutput({tag, ".strobe"}, 64'(seen), 64'd1);
    if (seen) begin
      checkOutput({tag, ".data"}, reg_wr_data_o, word);
      checkOutput({tag, ".gateLen"}, 64'(gh), 64'(gateLen));
      checkOutput({tag, ".syncAtStrobe"}, 64'(gate_sync_o), 64'd0);
      if (exactCyc >= 0) checkOutput({tag, ".latency"}, 64'(cyc), 64'(exactCyc));
    end
  endtask

  task automatic endMeasurement(input string tag);
    @(negedge clk_i);
    gate_en_i = 1'b0;
    @(posedge clk_i);
    #1;
    checkOutput({tag, ".oneShot"}, 64'(reg_wr_en_o), 64'd0);
  endtask

  task automatic runNormal(input string tag, input int p);
    applyStimulus(p);
    @(negedge clk_i);
    gate_en_i = 1'b1;
    measureAndCheck(tag, expWord(p), edgesInGate(p) * p, -1);
    endMeasurement(tag);
  endtask

  task automatic waitGateOpen(input string tag, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(posedge clk_i);
      #1;
      if (gate_sync_o) ok = 1'b1;
    end
    checkOutput({tag, ".gateOpens"}, 64'(ok), 64'd1);
  endtask

  task automatic runAbort(input string tag, input int p, input int k);
    bit ok;
    int strobes;
    applyStimulus(p);
    @(negedge clk_i);
    gate_en_i = 1'b1;
    waitGateOpen(tag, ok);
    repeat (k - 1) @(posedge clk_i);
    @(negedge clk_i);
    gate_en_i = 1'b0;
    @(posedge clk_i);
    #1;
    checkOutput({tag, ".syncDrops"}, 64'(gate_sync_o), 64'd0);
    strobes = (reg_wr_en_o) ? 1 : 0;
    repeat (150) begin
      @(posedge clk_i);
      #1;
      if (reg_wr_en_o) strobes++;
    end
    checkOutput({tag, ".noWrite"}, 64'(strobes), 64'd0);
    @(negedge clk_i);
    gate_en_i = 1'b1;
    measureAndCheck({tag, ".retry"}, expWord(p), edgesInGate(p) * p, -1);
    endMeasurement(tag);
  endtask

  task automatic runGateTimeout(input string tag, input int p);
    bit ok, seen;
    int cyc, gh;
    applyStimulus(p);
    @(negedge clk_i);
    gate_en_i = 1'b1;
    waitGateOpen(tag, ok);
    sigPeriod = 0;
    waitStrobe(1000, seen, cyc, gh);
    checkOutput({tag, ".strobe"}, 64'(seen), 64'd1);
    checkOutput({tag, ".data"}, reg_wr_data_o, NoSig);
    checkOutput({tag, ".gateLen"}, 64'(gh + 1), 64'(TOLEN));
    endMeasurement(tag);
  endtask

  initial begin
    bit ok, seen;
    int cyc, gh, nMeas, p;
    rst_n_i   = 1'b0;
    gate_en_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    checkOutput("reset.wrEn", 64'(reg_wr_en_o), 64'd0);
    checkOutput("reset.data", reg_wr_data_o, 64'd0);
    checkOutput("reset.gateSync", 64'(gate_sync_o), 64'd0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    repeat (3) @(posedge clk_i);

    runNormal("period10", 10);
    runNormal("period7", 7);

    // Held-low signal: ARM times out; the strobe shows on the TOLEN+1-th edge after the edge that saw gate_en.
    applyStimulus(0);
    @(negedge clk_i);
    gate_en_i = 1'b1;
    measureAndCheck("noSignal", NoSig, 0, TOLEN + 2);
    endMeasurement("noSignal");

    runAbort("abort50", 10, 50);

    // Continuous gating: every result identical, strobes spaced by one gate plus one period.
    applyStimulus(10);
    @(negedge clk_i);
    gate_en_i = 1'b1;
    nMeas = 2000 / ((edgesInGate(10) + 1) * 10) - 1;
    for (int i = 0; i < nMeas; i++) begin
      waitStrobe(600, seen, cyc, gh);
      checkOutput("b2b.strobe", 64'(seen), 64'd1);
      checkOutput("b2b.data", reg_wr_data_o, expWord(10));
      checkOutput("b2b.gateLen", 64'(gh), 64'(edgesInGate(10) * 10));
      if (i > 0) checkOutput("b2b.interval", 64'(cyc), 64'((edgesInGate(10) + 1) * 10));
    end
    endMeasurement("b2b");

    // Reset in the middle of a gate, then a clean measurement after release.
    applyStimulus(10);
    @(negedge clk_i);
    gate_en_i = 1'b1;
    waitGateOpen("midReset", ok);
    repeat (20) @(posedge clk_i);
    @(negedge clk_i);
    #2;
    rst_n_i = 1'b0;
    #1;
    checkOutput("midReset.wrEn", 64'(reg_wr_en_o), 64'd0);
    checkOutput("midReset.data", reg_wr_data_o, 64'd0);
    checkOutput("midReset.gateSync", 64'(gate_sync_o), 64'd0);
    applyStimulus(0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    repeat (3) @(posedge clk_i);
    applyStimulus(10);
    measureAndCheck("afterReset", expWord(10), edgesInGate(10) * 10, -1);
    endMeasurement("afterReset");

    // Randomized periods and scenarios.
    for (int it = 0; it < 12; it++) begin
      p = int'($urandom_range(45, 3));
      case ($urandom_range(2, 0))
        0: runNormal($sformatf("rnd%0d.normal.p%0d", it, p), p);
        1: runAbort($sformatf("rnd%0d.abort.p%0d", it, p), p, int'($urandom_range(GLEN - 1, 1)));
        default: runGateTimeout($sformatf("rnd%0d.gateTimeout.p%0d", it, p), p);
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/gate_counter.md
Name: gate_counter

Overview:
- Per-channel measurement stage. Counts reference-clock cycles and signal rising edges over a gate that is aligned to signal edges (equal-precision method).
- Sits between the gate sequencer, which drives gate_en_i, and the top-level write mux and regfile, which consume reg_wr_en_o and reg_wr_data_o.
- Five instances run staggered in time.
- Firmware computes f_sig = sig_cnt * f_clk / ref_cnt.

Parameters:
- CNT_WIDTH, 32, width of each counter; the result word is 2*CNT_WIDTH.
- GATE_CYCLES, 50_000_000, minimum gate length in clk_i cycles.
- TIMEOUT_CYCLES, 100_000_000, cycles without a qualifying edge before a no-signal result is written; must be greater than GATE_CYCLES.
- SYNC_STAGES, 2, flip-flop depth of the sig_clk_i synchronizer.

Ports:
- clk_i  in  1  system clock.
- rst_n_i  in  1  asynchronous reset, active low.
- sig_clk_i  in  1  signal under test; asynchronous to clk_i; sampled, never used as a clock.
- gate_en_i  in  1  level; measurement permitted while high.
- reg_wr_en_o  out  1  one-cycle result-valid strobe.
- reg_wr_data_o  out  2*CNT_WIDTH  {ref_cnt, sig_cnt}, with ref_cnt in the upper half.
- gate_sync_o  out  1  high while the edge-aligned gate is open.

Behaviour:
- Clocking and reset: one clock, clk_i. Reset is asynchronous, active low, on rst_n_i.
- Outputs in reset: reg_wr_en_o=0, reg_wr_data_o=0, gate_sync_o=0.
- Internal state in reset: state=IDLE, all counters and timers 0, synchronizer flops 0.
- Edge detection: sig_clk_i passes through SYNC_STAGES flops, then a previous-value flop. sig_rise = sync & ~prev.
  - Latency is SYNC_STAGES+1 cycles and is identical for the opening and closing edges, so it cancels.
- Time reference: t0 is the opening-edge cycle. timer = cycles elapsed since t0 in GATE, or since ARM entry in ARM.
- IDLE: if gate_en_i=1, go to ARM and clear the timer.
- ARM: waiting for the opening edge.
  - On sig_rise: ref_cnt=0, sig_cnt=0, timer=0; go to GATE; gate_sync_o=1 from the next cycle.
  - If timer reaches TIMEOUT_CYCLES: go to DONE with the no-signal word.
- GATE: each cycle, ref_cnt+1 and timer+1. On each sig_rise, sig_cnt+1.
  - Closing edge: the first sig_rise in a cycle where t-t0 >= GATE_CYCLES. That edge is counted, ref_cnt ends at t1-t0, and the FSM goes to DONE.
  - If timer reaches TIMEOUT_CYCLES without a closing edge: go to DONE with the no-signal word.
- DONE: lasts exactly one cycle.
  - reg_wr_en_o=1 and reg_wr_data_o={ref_cnt, sig_cnt}; gate_sync_o=0.
  - Next state is ARM if gate_en_i=1, otherwise IDLE. Back-to-back measurements are allowed.
- No-signal word: {all-ones, zero}.
- Abort: gate_en_i=0 in ARM or GATE goes to IDLE next cycle.
  - No write is issued; gate_sync_o falls; the partial counts are discarded.
- Saturation: ref_cnt and sig_cnt saturate at all-ones and never wrap. The timer saturates at TIMEOUT_CYCLES.
- Data hold: reg_wr_data_o holds its last value between strobes, and reg_wr_en_o is never high on two consecutive cycles.
- Simultaneous events:
  - gate_en_i falling in the same cycle as the closing edge: abort wins, no write.
  - sig_rise in the same cycle as the timeout: the edge wins.
- Reset mid-operation: all outputs return to their reset values immediately (asynchronously); no partial write.

Decomposition:
- Shared package dfm_pkg holds:
  - the state enum gc_state_t {IDLE, ARM, GATE, DONE};
  - the constant CNT_WIDTH_DEF=32;
  - the localparam for the no-signal word.
- One sub-module, sig_edge_sync: parameterised SYNC_STAGES synchronizer plus rise detector; outputs sig_rise.

Test Plan:
All scenarios use GATE_CYCLES=100 and TIMEOUT_CYCLES=400.
1. sig_clk_i period 10 clk cycles (phase random relative to clk_i), gate_en_i=1 -> first write {100, 10}; gate_sync_o high for exactly 100 cycles.
2. sig_clk_i period 7 cycles -> write {105, 15}.
3. sig_clk_i held low, gate_en_i=1 -> write {32'hFFFF_FFFF, 32'h0} 401 cycles after ARM entry; gate_sync_o never rises.
4. Period 10, drop gate_en_i 50 cycles into GATE -> no strobe, gate_sync_o low one cycle later. Re-raise gate_en_i -> fresh result {100, 10}.
5. gate_en_i held high for 2000 cycles at period 10 -> repeated writes, each {100, 10}, each a single-cycle strobe.
6. Assert rst_n_i=0 mid-GATE -> all outputs 0 immediately. Release reset with gate_en_i=1 -> normal {100, 10}.
